// File: rtl/gbvga_fb_pkg.sv
// Shared types and geometry for the Game Boy VGA framebuffer arbiter.
package gbvga_fb_pkg;
  localparam int FB_W      = 160;
  localparam int FB_H      = 144;
  localparam int FB_WORDS  = FB_W * FB_H;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 2;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wentry_t;
endpackage

// File: rtl/gbvga_fb_wfifo.sv
// Capture write FIFO: registered occupancy, no pass-through when full.
module gbvga_fb_wfifo
  import gbvga_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fb_wentry_t               push_entry,
  input  logic                     pop,
  output fb_wentry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  fb_wentry_t     mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic           do_push, do_pop;

  assign full    = level == (PW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_entry;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gbvga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, capture writes are FIFO-buffered.
// Define GBVGA_FB_ARB_FAIR_EN to bound how long reads may starve pending writes.
module gbvga_fb_arbiter
  import gbvga_fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FB_WORDS   = FB_W * FB_H,
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_gnt,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  if (RAM_LAT < 1 || RAM_LAT > 3 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("gbvga_fb_arbiter: illegal parameter set");
  end

  fb_wentry_t           push_entry, head;
  logic                 full, empty, pop, starved;
  logic                 rd_oor, wr_oor;
  op_e                  op;
  logic [RAM_LAT:1]     vld_q;
  logic [RAM_LAT:0]     vld_pipe, zero_pipe;

  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready   = !full;
  assign rd_oor     = 32'(rd_addr) >= FB_WORDS;
  assign wr_oor     = 32'(head.addr) >= FB_WORDS;

  gbvga_fb_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_valid),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (fifo_level)
  );

`ifdef GBVGA_FB_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;

  // Saturates by construction: at STARVE_MAX the write is forced, which clears it.
  assign starved = !empty && (starve == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset || pop)         starve <= '0;
    else if (rd_gnt && !empty) starve <= starve + 1'b1;
  end
`else
  assign starved = 1'b0;
`endif

  assign rd_gnt = !reset && rd_req && !starved;
  assign pop    = !reset && !rd_gnt && !empty;

  // Stage 0 of the read-return pipe is the issue register itself.
  assign vld_pipe = {vld_q, op == OP_RD};
  assign rd_valid = vld_pipe[RAM_LAT];
  assign rd_data  = (rd_valid && !zero_pipe[RAM_LAT]) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      op        <= OP_IDLE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      vld_q     <= '0;
      zero_pipe <= '0;
    end else begin
      ram_we    <= 1'b0;
      vld_q     <= vld_pipe[RAM_LAT-1:0];
      zero_pipe <= {zero_pipe[RAM_LAT-1:0], rd_oor};
      if (rd_gnt) begin
        op <= OP_RD;
        if (!rd_oor) ram_addr <= rd_addr;
      end else if (pop) begin
        op <= OP_WR;
        if (!wr_oor) begin
          ram_addr  <= head.addr;
          ram_wdata <= head.data;
          ram_we    <= 1'b1;
        end
      end else begin
        op <= OP_IDLE;
      end
    end
  end
endmodule
